// File: rtl/rx_packet_commit_fifo.sv
// Receive packet FIFO: words are buffered as they arrive and only become visible
// to the reader once the whole packet is committed by a non-zero match at EOP.
module rx_packet_commit_fifo #(
   parameter int DEPTH     = 64,
   parameter int TAG_DEPTH = 8
) (
   input  logic        clk_net,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [76:0] fifo_in,
   input  logic        buffer_valid,
   input  logic [7:0]  buffer_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic [2:0]  out_length,
   output logic        out_sop,
   output logic        out_eop,
   output logic [7:0]  out_buffer,
   output logic [15:0] commit_count,
   output logic [15:0] drop_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TAG_DEPTH);

   typedef enum logic [1:0] {IDLE, STORE, DISCARD} state_t;
   typedef logic [AW:0] ptr_t;
   typedef logic [TW:0] tptr_t;

   state_t      state;
   ptr_t        wr_ptr, cmt_ptr, rd_ptr;
   tptr_t       tag_wr, tag_rd;
   logic [68:0] mem [DEPTH];
   logic [7:0]  tag_mem [TAG_DEPTH];

   logic        in_sop, in_eop;
   logic        new_pkt, abort_old, writing, full, do_wr, tainted;
   logic        pkt_end, tag_full, commit, drop_new, rd_fire;
   ptr_t        base, fill, wr_next;
   logic [1:0]  drop_inc;
   logic [16:0] drop_sum, commit_sum;
   logic        unused_buf;

   // The detector's own buffer field is superseded by buffer_out at EOP.
   assign unused_buf = ^fifo_in[76:69];
   assign in_sop     = fifo_in[65];
   assign in_eop     = fifo_in[64];

   always_comb begin
      new_pkt   = in_valid && in_sop;
      abort_old = new_pkt && (state != IDLE);
      writing   = in_valid && (in_sop || state == STORE);
      // A new SOP restarts at the commit point, discarding any open packet.
      base      = new_pkt ? cmt_ptr : wr_ptr;
      fill      = base - rd_ptr;
      full      = (fill == ptr_t'(DEPTH));
      do_wr     = writing && !full;
      wr_next   = base + ptr_t'(do_wr);
      tainted   = (writing && full) || (state == DISCARD && !new_pkt);
      pkt_end   = in_valid && in_eop && (writing || state == DISCARD);
      tag_full  = ((tag_wr - tag_rd) == tptr_t'(TAG_DEPTH));
      commit    = pkt_end && !tainted && buffer_valid && (buffer_out != 8'd0) && !tag_full;
      drop_new  = pkt_end && !commit;
      drop_inc  = {1'b0, abort_old} + {1'b0, drop_new};
      drop_sum  = {1'b0, drop_count} + {15'd0, drop_inc};
      commit_sum = {1'b0, commit_count} + 17'd1;
      rd_fire   = out_valid && out_ready;
   end

   always_ff @(posedge clk_net or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         cmt_ptr      <= '0;
         rd_ptr       <= '0;
         tag_wr       <= '0;
         tag_rd       <= '0;
         commit_count <= '0;
         drop_count   <= '0;
      end else begin
         if (in_valid) begin
            if (pkt_end)      state <= IDLE;
            else if (tainted) state <= DISCARD;
            else if (writing) state <= STORE;
         end

         if (commit) begin
            wr_ptr  <= wr_next;
            cmt_ptr <= wr_next;
            tag_wr  <= tag_wr + tptr_t'(1);
         end else if (drop_new) begin
            wr_ptr <= cmt_ptr;
         end else if (writing) begin
            wr_ptr <= wr_next;
         end

         if (rd_fire) begin
            rd_ptr <= rd_ptr + ptr_t'(1);
            if (out_eop) tag_rd <= tag_rd + tptr_t'(1);
         end

         if (commit) commit_count <= commit_sum[16] ? 16'hFFFF : commit_sum[15:0];
         if (drop_inc != 2'd0) drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

   // Storage carries no reset; visibility is governed solely by the pointers.
   always_ff @(posedge clk_net) begin
      if (do_wr)  mem[base[AW-1:0]]       <= fifo_in[68:0];
      if (commit) tag_mem[tag_wr[TW-1:0]] <= buffer_out;
   end

   assign out_valid = (rd_ptr != cmt_ptr);
   assign {out_length, out_sop, out_eop, out_data} = mem[rd_ptr[AW-1:0]];
   assign out_buffer = tag_mem[tag_rd[TW-1:0]];
endmodule

// File: tb/tb_rx_packet_commit_fifo.sv
// Randomised bench for rx_packet_commit_fifo: a list-based packet model feeds a
// scoreboard queue that an independent monitor drains on every read handshake.
module tb_rx_packet_commit_fifo;
   localparam int DEPTH = 64;
   localparam int TAG_DEPTH = 8;

   logic        clk_net = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [76:0] fifo_in;
   logic        buffer_valid;
   logic [7:0]  buffer_out;
   logic        out_valid, out_ready;
   logic [63:0] out_data;
   logic [2:0]  out_length;
   logic        out_sop, out_eop;
   logic [7:0]  out_buffer;
   logic [15:0] commit_count, drop_count;

   rx_packet_commit_fifo #(.DEPTH(DEPTH), .TAG_DEPTH(TAG_DEPTH)) dut (
      .clk_net(clk_net), .rst(rst), .in_valid(in_valid), .fifo_in(fifo_in),
      .buffer_valid(buffer_valid), .buffer_out(buffer_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_length(out_length), .out_sop(out_sop), .out_eop(out_eop),
      .out_buffer(out_buffer), .commit_count(commit_count), .drop_count(drop_count)
   );

   always #5 clk_net = ~clk_net;

   typedef struct {
      logic [63:0] d;
      logic [2:0]  l;
      logic        s, e;
      logic [7:0]  b;
   } wd_t;

   typedef enum {M_IDLE, M_STORE, M_DISCARD} mode_t;

   wd_t   sb_q[$];   // committed, not yet read
   wd_t   open[$];   // packet under construction
   wd_t   pend[$];   // committed at the coming edge
   mode_t mode = M_IDLE;
   int    mcommit = 0, mdrop = 0, pc = 0, pd = 0;
   int    n_cmp = 0, n_err = 0;
   bit    mon_en = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // Monitor: outputs are stable by negedge+1; a handshake here transfers at the next posedge.
   always @(negedge clk_net) begin
      if (mon_en) begin
         #1;
         chk("out_valid", out_valid, sb_q.size() != 0);
         if (out_valid && out_ready && sb_q.size() != 0) begin
            wd_t w;
            w = sb_q.pop_front();
            chk("out_data", out_data, w.d);
            chk("out_length", out_length, w.l);
            chk("out_sop", out_sop, w.s);
            chk("out_eop", out_eop, w.e);
            chk("out_buffer", out_buffer, w.b);
         end
      end
   end

   function automatic int sat(input int v);
      return (v > 16'hFFFF) ? 16'hFFFF : v;
   endfunction

   // One clock of stimulus plus the packet-level reference model for it.
   task automatic step(input bit iv, input bit s, input bit e, input bit bv,
                       input logic [7:0] bo, input bit rd);
      wd_t w;
      int  tags;
      @(negedge clk_net);
      foreach (pend[i]) sb_q.push_back(pend[i]);
      pend.delete();
      mcommit = sat(mcommit + pc);
      mdrop   = sat(mdrop + pd);
      pc = 0; pd = 0;
      chk("commit_count", commit_count, mcommit);
      chk("drop_count", drop_count, mdrop);

      w.d = {$urandom, $urandom};
      w.l = 3'($urandom_range(0, 7));
      w.s = s; w.e = e; w.b = bo;
      in_valid     = iv;
      fifo_in      = {8'($urandom), w.l, s, e, w.d};
      buffer_valid = bv;
      buffer_out   = bo;
      out_ready    = rd;

      if (iv) begin
         if (s) begin
            if (mode != M_IDLE) pd++;
            open.delete();
            mode = M_STORE;
         end
         if (mode == M_STORE) begin
            if (sb_q.size() + open.size() >= DEPTH) begin
               mode = M_DISCARD;
               open.delete();
            end else open.push_back(w);
         end
         if (e && mode != M_IDLE) begin
            tags = 0;
            foreach (sb_q[i]) if (sb_q[i].e) tags++;
            if (mode == M_STORE && bv && bo != 8'd0 && tags < TAG_DEPTH) begin
               foreach (open[i]) begin
                  open[i].b = bo;
                  pend.push_back(open[i]);
               end
               pc++;
            end else pd++;
            open.delete();
            mode = M_IDLE;
         end
      end
   endtask

   task automatic idle(input int n, input bit rd);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'd0, rd);
   endtask

   task automatic send_pkt(input int n, input bit bv, input logic [7:0] bo, input bit rd);
      for (int i = 0; i < n; i++) step(1, i == 0, i == n - 1, bv, bo, rd);
   endtask

   task automatic drain();
      int i;
      i = 0;
      while ((sb_q.size() != 0 || pend.size() != 0) && i < 600) begin
         step(0, 0, 0, 0, 8'd0, 1);
         i++;
      end
      idle(2, 1);
      chk("drain_empty", sb_q.size(), 0);
   endtask

   initial begin
      bit iv, s, e, bv, rd;
      logic [7:0] bo;
      int rp;

      rst = 1; in_valid = 0; fifo_in = '0; buffer_valid = 0; buffer_out = 0; out_ready = 0;
      repeat (3) @(negedge clk_net);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_commit_count", commit_count, 0);
      chk("reset_drop_count", drop_count, 0);
      rst = 0;
      mon_en = 1;

      // Basic commit, then the same shape with no match.
      send_pkt(4, 1, 8'd1, 1); idle(8, 1);
      send_pkt(4, 1, 8'd0, 1); idle(4, 1);
      // Oversized packet with nothing read: overflow discard.
      send_pkt(70, 1, 8'd3, 0); idle(3, 0);
      drain();
      // SOP inside an open packet restarts it.
      step(1, 1, 0, 1, 8'd9, 1);
      step(1, 0, 0, 1, 8'd9, 1);
      send_pkt(3, 1, 8'd2, 1); idle(6, 1);
      // Tag FIFO exhaustion with single-word packets.
      for (int i = 0; i < 9; i++) send_pkt(1, 1, 8'(i + 1), 0);
      idle(2, 0);
      drain();

      // Randomised traffic, alternating fast and slow readers.
      for (int blk = 0; blk < 6; blk++) begin
         rp = (blk % 2) ? 15 : 70;
         for (int c = 0; c < 500; c++) begin
            iv = $urandom_range(0, 9) < 8;
            s  = $urandom_range(0, 5) == 0;
            e  = $urandom_range(0, 4) == 0;
            bv = $urandom_range(0, 9) < 8;
            bo = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            rd = $urandom_range(0, 99) < rp;
            step(iv, s, e, bv, bo, rd);
         end
      end
      drain();

      // Reset while a committed packet is visible and another is open.
      send_pkt(2, 1, 8'd4, 0);
      step(1, 1, 0, 1, 8'd4, 0);
      step(1, 0, 0, 1, 8'd4, 0);
      mon_en = 0;
      @(negedge clk_net);
      in_valid = 0;
      #2 rst = 1;
      #1;
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_commit_count", commit_count, 0);
      chk("midreset_drop_count", drop_count, 0);
      sb_q.delete(); open.delete(); pend.delete();
      mode = M_IDLE; mcommit = 0; mdrop = 0; pc = 0; pd = 0;
      @(negedge clk_net);
      rst = 0;
      mon_en = 1;
      step(1, 0, 0, 1, 8'd6, 1);
      step(1, 0, 1, 1, 8'd6, 1);
      send_pkt(3, 1, 8'd5, 1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
